// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with HI/LO result registers.
//
// A start request in IDLE either launches a multi-cycle MULT/MULTU (5 busy
// cycles) or DIV/DIVU (10 busy cycles), or writes HI/LO directly
// (MTHI/MTLO). Operands are captured at the start edge. The result is
// computed from those captured operands and committed on the last busy edge.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   request strobe, sampled on rising edge
//   op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   inA    in  32   operand A (rs) / MTHI-MTLO write data
//   inB    in  32   operand B (rt)
//   busy   out  1   operation in flight (registered)
//   done   out  1   one-cycle pulse after a MULT/DIV commit (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } stateT;

  // 64-bit product. Sign-extending both operands to 64 bits and keeping the
  // low 64 bits of the product yields the correct signed or unsigned result.
  function automatic logic [63:0] mulResult(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        isSigned);
    logic [63:0] extA;
    logic [63:0] extB;
    extA = {{32{isSigned & a[31]}}, a};
    extB = {{32{isSigned & b[31]}}, b};
    return extA * extB;
  endfunction

  // Returns {remainder, quotient}. Division is done on magnitudes so the
  // 0x80000000 / -1 overflow case wraps cleanly to 0x80000000 with remainder 0.
  // A zero divisor is replaced by 1 only to keep the divider well defined; the
  // controller discards the result in that case.
  function automatic logic [63:0] divResult(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        isSigned);
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] quo;
    logic [31:0] rem;
    negA = isSigned & a[31];
    negB = isSigned & b[31];
    magA = negA ? (32'd0 - a) : a;
    magB = negB ? (32'd0 - b) : b;
    if (magB == 32'd0) begin
      magB = 32'd1;
    end else begin
      magB = magB;
    end
    quo = magA / magB;
    rem = magA % magB;
    quo = (negA ^ negB) ? (32'd0 - quo) : quo;
    rem = negA ? (32'd0 - rem) : rem;
    return {rem, quo};
  endfunction

  stateT       stateR;
  stateT       nextStateS;
  logic [3:0]  cntR;
  logic [3:0]  nextCntS;
  logic [31:0] opAR;
  logic [31:0] opBR;
  logic        signedR;
  logic        loadOpsS;
  logic [31:0] hiR;
  logic [31:0] loR;
  logic [31:0] nextHiS;
  logic [31:0] nextLoS;
  logic        busyR;
  logic        doneR;
  logic        nextDoneS;
  logic [63:0] mulS;
  logic [63:0] divS;
  logic        divByZeroS;

  assign mulS       = mulResult(opAR, opBR, signedR);
  assign divS       = divResult(opAR, opBR, signedR);
  assign divByZeroS = (opBR == 32'd0);

  assign busy = busyR;
  assign done = doneR;
  assign hi   = hiR;
  assign lo   = loR;

  // Next-state, counter and HI/LO write decode.
  always_comb begin
    nextStateS = stateR;
    nextCntS   = cntR;
    loadOpsS   = 1'b0;
    nextHiS    = hiR;
    nextLoS    = loR;
    nextDoneS  = 1'b0;
    case (stateR)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              nextStateS = MUL;
              nextCntS   = MUL_CYCLES;
              loadOpsS   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              nextStateS = DIV;
              nextCntS   = DIV_CYCLES;
              loadOpsS   = 1'b1;
            end
            OP_MTHI: nextHiS = inA;
            OP_MTLO: nextLoS = inA;
            default: nextStateS = IDLE;
          endcase
        end else begin
          nextStateS = IDLE;
        end
      end
      MUL: begin
        // Commit on the edge where the counter leaves 1; a counter already at
        // 0 also commits so a corrupted count can never stall the unit.
        if (cntR <= 4'd1) begin
          nextStateS = IDLE;
          nextCntS   = 4'd0;
          nextHiS    = mulS[63:32];
          nextLoS    = mulS[31:0];
          nextDoneS  = 1'b1;
        end else begin
          nextCntS = cntR - 4'd1;
        end
      end
      DIV: begin
        if (cntR <= 4'd1) begin
          nextStateS = IDLE;
          nextCntS   = 4'd0;
          nextDoneS  = 1'b1;
          if (!divByZeroS) begin
            nextHiS = divS[63:32];
            nextLoS = divS[31:0];
          end else begin
            nextHiS = hiR;
            nextLoS = loR;
          end
        end else begin
          nextCntS = cntR - 4'd1;
        end
      end
      default: begin
        nextStateS = IDLE;
        nextCntS   = 4'd0;
      end
    endcase
  end

  // State, counter, captured operands and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR  <= IDLE;
      cntR    <= 4'd0;
      opAR    <= 32'd0;
      opBR    <= 32'd0;
      signedR <= 1'b0;
      hiR     <= 32'd0;
      loR     <= 32'd0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
    end else begin
      stateR <= nextStateS;
      cntR   <= nextCntS;
      if (loadOpsS) begin
        opAR    <= inA;
        opBR    <= inB;
        signedR <= ~op[0];
      end else begin
        opAR    <= opAR;
        opBR    <= opBR;
        signedR <= signedR;
      end
      hiR   <= nextHiS;
      loR   <= nextLoS;
      busyR <= (nextStateS != IDLE);
      doneR <= nextDoneS;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a scoreboard queue of expected
// {hi, lo, busy length} entries is filled by the stimulus and drained by a
// monitor on every done pulse.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] len;
  } expT;

  expT  sb[$];
  expT  cur;
  int   nAssert = 0;
  int   nFail   = 0;
  int   runLen  = 0;
  logic prevDone = 1'b0;

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: on each done pulse pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      runLen   = 0;
      prevDone = 1'b0;
    end else begin
      if (done === 1'b1) begin
        check32("done_single_cycle", {31'd0, prevDone}, 32'd0);
        if (sb.size() == 0) begin
          nAssert++;
          nFail++;
          $display("FAIL unexpected_done: got done=1 with hi=0x%08h lo=0x%08h, expected no done", hi, lo);
        end else begin
          cur = sb.pop_front();
          check32("hi", hi, cur.hi);
          check32("lo", lo, cur.lo);
          check32("busy_len", runLen, cur.len);
        end
      end
      if (busy === 1'b1) runLen++;
      else runLen = 0;
      prevDone = done;
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic [31:0] len);
    expT e;
    e.hi  = h;
    e.lo  = l;
    e.len = len;
    sb.push_back(e);
  endtask

  // One-cycle start strobe, then scramble the operand inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    @(negedge clk);
    start = 1'b0;
    inA   = $urandom;
    inB   = $urandom;
  endtask

  task automatic waitIdle();
    int budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      nAssert++;
      nFail++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic [31:0] len);
    push(h, l, len);
    issue(o, a, b);
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] loBefore;
    int          doneCnt;
    int          budget;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    inA   = 32'd0;
    inB   = 32'd0;
    #12;
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT with an MTLO and a DIV attempted while busy; both must be ignored.
    push(32'hFFFFFFFF, 32'hFFFFFFF1, 32'd5);
    issue(3'b000, 32'hFFFFFFFD, 32'd5);
    loBefore = lo;
    start = 1'b1;
    op    = 3'b101;
    inA   = 32'h0000AAAA;
    @(negedge clk);
    check32("mtlo_ignored", lo, loBefore);
    check32("busy_during_mult", {31'd0, busy}, 32'd1);
    op  = 3'b010;
    inA = 32'd100;
    inB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    runOp(3'b001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 32'd5);
    runOp(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd10);
    runOp(3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 32'd10);
    runOp(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'd10);
    runOp(3'b000, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000, 32'd5);

    // MTHI / MTLO take effect at the start edge with no busy or done.
    issue(3'b100, 32'h00001234, 32'd0);
    check32("mthi_hi", hi, 32'h00001234);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    check32("mthi_done", {31'd0, done}, 32'd0);
    issue(3'b101, 32'h00005678, 32'd0);
    check32("mtlo_lo", lo, 32'h00005678);
    check32("mtlo_busy", {31'd0, busy}, 32'd0);
    check32("mtlo_done", {31'd0, done}, 32'd0);

    // NOP opcode: nothing changes.
    issue(3'b110, 32'hDEADBEEF, 32'd1);
    check32("nop_busy", {31'd0, busy}, 32'd0);
    check32("nop_hi", hi, 32'h00001234);

    // Divide by zero leaves HI/LO untouched but still completes.
    runOp(3'b011, 32'd99, 32'd0, 32'h00001234, 32'h00005678, 32'd10);

    // Back-to-back: second MULT issued in the done cycle of the first.
    push(32'd0, 32'd12, 32'd5);
    push(32'd0, 32'd42, 32'd5);
    issue(3'b000, 32'd3, 32'd4);
    budget = 20;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    start = 1'b1;
    op    = 3'b000;
    inA   = 32'd6;
    inB   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check32("b2b_accepted", {31'd0, busy}, 32'd1);
    waitIdle();

    // Put known nonzero values in HI/LO, then reset in busy cycle 3 of a DIV.
    issue(3'b100, 32'h0000BEEF, 32'd0);
    issue(3'b010, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_done", {31'd0, done}, 32'd0);
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    check32("midrst_no_done", doneCnt, 32'd0);
    check32("midrst_lo_held", lo, 32'd0);

    // Start accepted on the first edge after reset release.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push(32'd0, 32'd6, 32'd5);
    start = 1'b1;
    op    = 3'b001;
    inA   = 32'd2;
    inB   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check32("post_rst_start", {31'd0, busy}, 32'd1);
    waitIdle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
